alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have parameter BUS_WIDTH, default 8, which is the operand/result width.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, which is the number of command FIFO entries (power of 2, >=2).
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-004 Port rst, input, 1 bit: reset, which SHALL be asynchronous and active-high.
REQ-005 Port cmd_valid, input, 1 bit: command offered.
REQ-006 Port cmd_ready, output, 1 bit: command FIFO not full.
REQ-007 Port cmd_opcode, input, 4 bits: ALU opcode (1=ADD, 2=ADD_CARRY, 3=SUB, 4=INC, 5=DEC, 6=AND, 7=NOT, 8=ROL, 9=ROR).
REQ-008 Ports cmd_a and cmd_b, inputs, BUS_WIDTH bits each: the operands.
REQ-009 Port carry_clr, input, 1 bit: clears the chained carry.
REQ-010 Ports alu_opcode (4), alu_a, alu_b (BUS_WIDTH) and alu_carry_in (1), outputs, all registered: drive the ALU.
REQ-011 Ports alu_y (BUS_WIDTH), alu_carry_out, alu_borrow, alu_zero, alu_parity and alu_invalid_op (1 each), inputs: combinational ALU results.
REQ-012 Ports res_valid and res_ready: output and input respectively, 1 bit each; result handshake.
REQ-013 Ports res_y (BUS_WIDTH) and res_flags (5), outputs: captured result; res_flags = {invalid_op, parity, zero, borrow, carry_out}.

Function
REQ-014 A command SHALL be pushed into the FIFO at each rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal !full, with no combinational path from cmd_valid.
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 In IDLE with the FIFO non-empty, the next edge SHALL pop the FIFO head, load alu_opcode, alu_a, alu_b and alu_carry_in=carry_reg, and enter WAIT. There SHALL be no same-cycle bypass of an empty FIFO.
REQ-017 In WAIT, the next edge SHALL capture alu_y into res_y and the flag inputs into res_flags, set res_valid=1 and enter RESP.
REQ-018 In RESP, res_valid, res_y and res_flags SHALL hold stable until an edge with res_ready=1; that edge SHALL clear res_valid and return the FSM to IDLE.
REQ-019 Latency: for a command accepted at edge E into an empty FIFO with the FSM in IDLE, res_valid SHALL be high after edge E+2. Sustained throughput SHALL be one command per 3 cycles when res_ready is held at 1.
REQ-020 carry_reg SHALL be loaded with alu_carry_out at the WAIT capture edge only when the captured opcode is 1 or 2; all other opcodes SHALL leave carry_reg unchanged.
REQ-021 If carry_clr=1, carry_reg SHALL be 0 at the next edge; carry_clr SHALL win over a simultaneous capture. Pops SHALL be unaffected.
REQ-022 Opcodes 0 and 10-15 SHALL be issued unchanged, and the alu_invalid_op input SHALL be reported in res_flags[4].
REQ-023 When the FIFO is full, cmd_ready SHALL be 0 and a push SHALL never overwrite an entry; a pop from a full FIFO SHALL raise cmd_ready at the following edge.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-025 Asserting rst SHALL immediately force: FSM to IDLE, FIFO empty, cmd_ready=1, res_valid=0, res_y=0, res_flags=0, alu_opcode=0, alu_a=0, alu_b=0, alu_carry_in=0, carry_reg=0.
REQ-026 Reset asserted mid-command SHALL discard the in-flight command and all queued commands; no res_valid SHALL appear for them after rst deasserts.

Configuration
REQ-027 With macro ALU_SEQUENCER_STATS_EN defined, the module SHALL add two outputs, stat_issued[15:0] and stat_invalid[15:0]. Each SHALL reset to 0 and saturate at 16'hFFFF. stat_issued SHALL increment on each pop, and stat_invalid SHALL increment on each capture with alu_invalid_op=1.
REQ-028 Without ALU_SEQUENCER_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL model the ALU combinationally against alu_* and check each result against the model using case equality.
REQ-030 Single ADD: a=8'hF0, b=8'h20, accepted at edge E -> res_valid after E+2, res_y=8'h10, res_flags=5'b00001.
REQ-031 Carry chain: ADD 8'hFF+8'h01, then ADD_CARRY 8'h00+8'h00 -> second result alu_carry_in=1, res_y=8'h01, res_flags=5'b01000. Repeating this sequence with carry_clr pulsed between the two commands -> res_y=8'h00, res_flags=5'b00100.
REQ-032 Backpressure: res_ready=0, push 5 commands with FIFO_DEPTH=4 -> cmd_ready=0 after 4 FIFO entries plus 1 in flight; release res_ready -> all 5 results are delivered in order, with none lost or duplicated.
REQ-033 Invalid opcode 4'd12, a=8'h55 -> res_flags[4]=1, res_y=8'h00, res_flags=5'b10100; with ALU_SEQUENCER_STATS_EN defined -> stat_invalid=1.
REQ-034 Reset asserted while in WAIT with 2 commands queued -> all outputs equal their REQ-025 values immediately; after deassertion, no res_valid appears within 10 cycles.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bundle of command, ALU-drive, ALU-result and response signals for alu_sequencer.
// slave is the sequencer's view; master is the view of whatever drives/consumes it.
interface alu_sequencer_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_opcode;
  logic [BUS_WIDTH-1:0] cmd_a;
  logic [BUS_WIDTH-1:0] cmd_b;
  logic                 carry_clr;

  logic [3:0]           alu_opcode;
  logic [BUS_WIDTH-1:0] alu_a;
  logic [BUS_WIDTH-1:0] alu_b;
  logic                 alu_carry_in;

  logic [BUS_WIDTH-1:0] alu_y;
  logic                 alu_carry_out;
  logic                 alu_borrow;
  logic                 alu_zero;
  logic                 alu_parity;
  logic                 alu_invalid_op;

  logic                 res_valid;
  logic                 res_ready;
  logic [BUS_WIDTH-1:0] res_y;
  logic [4:0]           res_flags;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, carry_clr,
    input  alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
    input  res_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b, alu_carry_in,
    output res_valid, res_y, res_flags
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, carry_clr,
    output alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
    output res_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b, alu_carry_in,
    input  res_valid, res_y, res_flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// Queues ALU commands in a FIFO, issues them one at a time to an external ALU and
// returns registered results; define ALU_SEQUENCER_STATS_EN to add issue/invalid counters.
module alu_sequencer #(
  parameter int BUS_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_sequencer_if.slave     bus
`ifdef ALU_SEQUENCER_STATS_EN
  ,
  output logic [15:0]        stat_issued,
  output logic [15:0]        stat_invalid
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic [3:0]           op_mem [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0] a_mem  [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0] b_mem  [FIFO_DEPTH];

  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic                 full, empty, push, pop, capture, release_res;

  logic [3:0]           alu_opcode_q;
  logic [BUS_WIDTH-1:0] alu_a_q, alu_b_q;
  logic                 alu_carry_in_q;
  logic                 carry_q;
  logic                 res_valid_q;
  logic [BUS_WIDTH-1:0] res_y_q;
  logic [4:0]           res_flags_q;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus.cmd_valid && !full;

  assign bus.cmd_ready    = !full;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_carry_in = alu_carry_in_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_y        = res_y_q;
  assign bus.res_flags    = res_flags_q;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q[AW-1:0]] <= bus.cmd_opcode;
      a_mem[wr_ptr_q[AW-1:0]]  <= bus.cmd_a;
      b_mem[wr_ptr_q[AW-1:0]]  <= bus.cmd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          release_res = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode_q   <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_carry_in_q <= 1'b0;
    end else if (pop) begin
      alu_opcode_q   <= op_mem[rd_ptr_q[AW-1:0]];
      alu_a_q        <= a_mem[rd_ptr_q[AW-1:0]];
      alu_b_q        <= b_mem[rd_ptr_q[AW-1:0]];
      alu_carry_in_q <= carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_flags_q <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_y_q     <= bus.alu_y;
      res_flags_q <= {bus.alu_invalid_op, bus.alu_parity, bus.alu_zero,
                      bus.alu_borrow, bus.alu_carry_out};
    end else if (release_res) begin
      res_valid_q <= 1'b0;
    end
  end

  // Only ADD/ADD_CARRY feed the chained carry; an explicit clear overrides them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (bus.carry_clr) begin
      carry_q <= 1'b0;
    end else if (capture && (alu_opcode_q == 4'd1 || alu_opcode_q == 4'd2)) begin
      carry_q <= bus.alu_carry_out;
    end
  end

`ifdef ALU_SEQUENCER_STATS_EN
  logic [15:0] stat_issued_q, stat_invalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q  <= '0;
      stat_invalid_q <= '0;
    end else begin
      if (pop && stat_issued_q != 16'hFFFF)
        stat_issued_q <= stat_issued_q + 16'd1;
      if (capture && bus.alu_invalid_op && stat_invalid_q != 16'hFFFF)
        stat_invalid_q <= stat_invalid_q + 16'd1;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_invalid = stat_invalid_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a combinational ALU model answers the DUT,
// directed commands queue hand-computed results, a monitor checks each handshake.
module tb_alu_sequencer;
  localparam int BW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if #(.BUS_WIDTH(BW)) bus ();

`ifdef ALU_SEQUENCER_STATS_EN
  logic [15:0] stat_issued, stat_invalid;
`endif

  alu_sequencer #(.BUS_WIDTH(BW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ALU_SEQUENCER_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_invalid(stat_invalid)
`endif
  );

  // Returns {y, invalid, parity, zero, borrow, carry}; parity is XOR of the low nibble.
  function automatic logic [BW+4:0] alu_model(input logic [3:0] op, input logic [BW-1:0] a,
                                              input logic [BW-1:0] b, input logic cin);
    logic [BW:0]   s;
    logic [BW-1:0] y;
    logic          c, br, inv;
    s = '0; y = '0; c = 1'b0; br = 1'b0; inv = 1'b0;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; y = s[BW-1:0]; c = s[BW]; end
      4'd2: begin s = {1'b0, a} + {1'b0, b} + {{BW{1'b0}}, cin}; y = s[BW-1:0]; c = s[BW]; end
      4'd3: begin y = a - b; br = (a < b); end
      4'd4: begin s = {1'b0, a} + {{BW{1'b0}}, 1'b1}; y = s[BW-1:0]; c = s[BW]; end
      4'd5: begin y = a - {{(BW-1){1'b0}}, 1'b1}; br = (a == '0); end
      4'd6: y = a & b;
      4'd7: y = ~a;
      4'd8: y = {a[BW-2:0], a[BW-1]};
      4'd9: y = {a[0], a[BW-1:1]};
      default: inv = 1'b1;
    endcase
    return {y, inv, ^y[3:0], (y == '0), br, c};
  endfunction

  always_comb begin
    {bus.alu_y, bus.alu_invalid_op, bus.alu_parity, bus.alu_zero, bus.alu_borrow,
     bus.alu_carry_out} = alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry_in);
  end

  typedef struct {
    logic [BW-1:0] y;
    logic [4:0]    f;
    logic          chk_cin;
    logic          cin;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int n_recv   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  exp_t          mon_e;
  logic [BW+4:0] mon_m;

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", bus.res_y);
      end else begin
        mon_e = sb.pop_front();
        n_recv++;
        chk("res_y", 32'(bus.res_y), 32'(mon_e.y));
        chk("res_flags", 32'(bus.res_flags), 32'(mon_e.f));
        mon_m = alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry_in);
        chk("model_y", 32'(bus.res_y), 32'(mon_m[BW+4:5]));
        chk("model_flags", 32'(bus.res_flags), 32'(mon_m[4:0]));
        if (mon_e.chk_cin) chk("alu_carry_in", 32'(bus.alu_carry_in), 32'(mon_e.cin));
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic [BW-1:0] ey, input logic [4:0] ef,
                      input logic chk_cin = 1'b0, input logic cin = 1'b0);
    int t;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    t = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=cmd_ready_low required=accept");
    end else begin
      sb.push_back(exp_t'{ey, ef, chk_cin, cin});
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},    32'(bus.cmd_ready), 32'd1);
    chk({tag, "_res_valid"},    32'(bus.res_valid), 32'd0);
    chk({tag, "_res_y"},        32'(bus.res_y), 32'd0);
    chk({tag, "_res_flags"},    32'(bus.res_flags), 32'd0);
    chk({tag, "_alu_opcode"},   32'(bus.alu_opcode), 32'd0);
    chk({tag, "_alu_a"},        32'(bus.alu_a), 32'd0);
    chk({tag, "_alu_b"},        32'(bus.alu_b), 32'd0);
    chk({tag, "_alu_carry_in"}, 32'(bus.alu_carry_in), 32'd0);
`ifdef ALU_SEQUENCER_STATS_EN
    chk({tag, "_stat_issued"},  32'(stat_issued), 32'd0);
    chk({tag, "_stat_invalid"}, 32'(stat_invalid), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.carry_clr  = 1'b0;
    bus.res_ready  = 1'b1;
    #12;
    chk_reset_outputs("init");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single ADD with latency E+2
    send(4'd1, 8'hF0, 8'h20, 8'h10, 5'b00001);
    @(negedge clk);
    @(negedge clk);
    chk("lat_e1_res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    chk("lat_e2_res_valid", 32'(bus.res_valid), 32'd1);
    wait_drain();

    // Carry chain
    send(4'd1, 8'hFF, 8'h01, 8'h00, 5'b00101);
    send(4'd2, 8'h00, 8'h00, 8'h01, 5'b01000, 1'b1, 1'b1);
    wait_drain();

    // Carry chain with carry_clr pulsed between the two commands
    send(4'd1, 8'hFF, 8'h01, 8'h00, 5'b00101);
    wait_drain();
    bus.carry_clr = 1'b1;
    @(posedge clk);
    #1 bus.carry_clr = 1'b0;
    send(4'd2, 8'h00, 8'h00, 8'h00, 5'b00100, 1'b1, 1'b0);
    wait_drain();

    // carry_clr on the same edge as the ADD capture
    send(4'd1, 8'hFF, 8'h01, 8'h00, 5'b00101);
    @(posedge clk);
    #1 bus.carry_clr = 1'b1;
    @(posedge clk);
    #1 bus.carry_clr = 1'b0;
    wait_drain();
    send(4'd2, 8'h00, 8'h00, 8'h00, 5'b00100, 1'b1, 1'b0);
    wait_drain();

    // Invalid opcode and a couple of logic ops
    send(4'd12, 8'h55, 8'h00, 8'h00, 5'b10100);
    wait_drain();
`ifdef ALU_SEQUENCER_STATS_EN
    chk("stat_invalid", 32'(stat_invalid), 32'd1);
`endif
    send(4'd7, 8'h5A, 8'h00, 8'hA5, 5'b00000);
    send(4'd9, 8'h01, 8'h00, 8'h80, 5'b00000);
    wait_drain();

    // Backpressure: 1 in flight + 4 queued fills the FIFO
    base = n_recv;
    bus.res_ready = 1'b0;
    send(4'd3, 8'h10, 8'h20, 8'hF0, 5'b00010);
    send(4'd4, 8'hFF, 8'h00, 8'h00, 5'b00101);
    send(4'd6, 8'hF3, 8'h3C, 8'h30, 5'b00000);
    send(4'd8, 8'h81, 8'h00, 8'h03, 5'b00000);
    send(4'd5, 8'h00, 8'h00, 8'hFF, 5'b00010);
    @(negedge clk);
    chk("bp_full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("bp_res_valid_held", 32'(bus.res_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 4'd4;
    bus.cmd_a      = 8'h77;
    repeat (3) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    chk("bp_still_full", 32'(bus.cmd_ready), 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_pre_release_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("bp_idle_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("bp_pop_ready", 32'(bus.cmd_ready), 32'd1);
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    chk("bp_result_count", 32'(n_recv), 32'(base + 5));

    // Reset while WAIT with two commands queued
    bus.res_ready = 1'b0;
    send(4'd1, 8'hFF, 8'h01, 8'h00, 5'b00101);
    send(4'd6, 8'hFF, 8'h0F, 8'h0F, 5'b00000);
    send(4'd6, 8'hF0, 8'hFF, 8'hF0, 5'b00000);
    send(4'd7, 8'h00, 8'h00, 8'hFF, 5'b00000);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    chk_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.res_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) seen++;
    end
    chk("no_res_after_rst", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    send(4'd2, 8'h00, 8'h00, 8'h00, 5'b00100, 1'b1, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
